// File: rtl/mix_sample_fifo.sv
// Four-voice drum mixer: sums offset-binary voices into a signed 32-bit word once
// per sample tick and buffers the words in a small FIFO drained by valid/ready.
module mix_sample_fifo #(
  parameter int unsigned DIV   = 1042,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [7:0]    audio0,
  input  logic [7:0]    audio1,
  input  logic [7:0]    audio2,
  input  logic [7:0]    audio3,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic [7:0]    drop_count
);

  localparam logic [15:0] TICK_AT = 16'(DIV - 1);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  logic [15:0]   div_q, div_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   mem_q [DEPTH];

  logic               tick;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic signed [9:0]  mix_sum;
  logic [31:0]        mix_word;

  function automatic logic signed [9:0] centred(input logic [7:0] v);
    return $signed({2'b00, v}) - 10'sd128;
  endfunction

  // Four values in -128..127 always fit in 10 signed bits, so no saturation.
  always_comb begin
    mix_sum  = centred(audio0) + centred(audio1) + centred(audio2) + centred(audio3);
    mix_word = en ? {mix_sum, 22'b0} : '0;
  end

  always_comb begin
    tick    = (div_q == TICK_AT);
    div_d   = tick ? '0 : div_q + 16'd1;
    pop     = (level_q != '0) && out_ready;
    push_ok = tick && ((level_q < FULL) || pop);
    drop    = tick && !push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    overrun_d = overrun_q | drop;
    drop_d    = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      div_q     <= div_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= mix_word;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mix_sample_fifo.sv
// Directed bench for mix_sample_fifo with DIV=4, DEPTH=4: mix arithmetic table,
// overrun/drain, full-with-pop and asynchronous mid-stream reset sequences.
module tb_mix_sample_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  audio0 = 8'd128, audio1 = 8'd128, audio2 = 8'd128, audio3 = 8'd128;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        overrun;
  logic [7:0]  drop_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  mix_sample_fifo #(.DIV(4), .DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .audio0     (audio0),
    .audio1     (audio1),
    .audio2     (audio2),
    .audio3     (audio3),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a0, a1, a2, a3;
    logic        en;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Advance to the cycle just after the next tick push edge.
  task automatic to_tick_end();
    step();
    while (cyc % 4 != 0) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] drain1 [5];
    logic [31:0] drain2 [4];

    vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 1'b1, 32'h0000_0000};
    vecs[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 32'h7F00_0000};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 32'h8000_0000};
    vecs[3] = '{8'd200, 8'd128, 8'd128, 8'd100, 1'b1, 32'h0B00_0000};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 32'h0000_0000};
    vecs[5] = '{8'd129, 8'd128, 8'd128, 8'd128, 1'b1, 32'h0040_0000};
    vecs[6] = '{8'd127, 8'd128, 8'd128, 8'd128, 1'b1, 32'hFFC0_0000};

    drain1[0] = 32'h0040_0000; drain1[1] = 32'h0080_0000; drain1[2] = 32'h00C0_0000;
    drain1[3] = 32'h0100_0000; drain1[4] = 32'h0300_0000;
    drain2[0] = 32'h02C0_0000; drain2[1] = 32'h0300_0000; drain2[2] = 32'h0340_0000;
    drain2[3] = 32'h0500_0000;

    // Reset / idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("idle_valid_low", 32'(out_valid), 32'd0);
    end
    step();
    chk("first_tick_valid", 32'(out_valid), 32'd1);
    chk("first_tick_data", out_data, 32'd0);

    // Arithmetic table
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      audio0 = vecs[i].a0; audio1 = vecs[i].a1;
      audio2 = vecs[i].a2; audio3 = vecs[i].a3;
      en = vecs[i].en;
      to_tick_end();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      step();
      chk($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'd0);
    end

    // Overrun: six ticks with no consumer
    out_ready = 1'b0;
    en = 1'b1;
    audio1 = 8'd128; audio2 = 8'd128; audio3 = 8'd128;
    for (int t = 0; t < 6; t++) begin
      audio0 = 8'(129 + t);
      to_tick_end();
      chk($sformatf("ovr_level_t%0d", t + 1), 32'(level), (t < 4) ? 32'(t + 1) : 32'd4);
      if (t == 3) chk("ovr_flag_before", 32'(overrun), 32'd0);
      if (t == 4) chk("ovr_flag_tick5", 32'(overrun), 32'd1);
      if (t == 4) chk("ovr_drops_tick5", 32'(drop_count), 32'd1);
    end
    chk("ovr_drops_final", 32'(drop_count), 32'd2);
    chk("ovr_head_stable", out_data, 32'h0040_0000);
    audio0 = 8'd140;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain1_w%0d", i), out_data, drain1[i]);
      step();
    end
    chk("drain1_level", 32'(level), 32'd0);
    chk("drain1_valid", 32'(out_valid), 32'd0);
    chk("drain1_drops", 32'(drop_count), 32'd2);

    // Full FIFO with pop landing in the tick cycle
    out_ready = 1'b0;
    audio0 = 8'd128;
    for (int t = 0; t < 4; t++) begin
      audio1 = 8'(138 + t);
      to_tick_end();
    end
    chk("full_level", 32'(level), 32'd4);
    audio1 = 8'd148;
    repeat (3) step();
    chk("full_level_pre", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();
    chk("fullpop_level", 32'(level), 32'd4);
    chk("fullpop_drops", 32'(drop_count), 32'd2);
    chk("fullpop_overrun", 32'(overrun), 32'd1);
    audio1 = 8'd128;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain2_w%0d", i), out_data, drain2[i]);
      if (i < 3) step();
    end
    chk("drain2_level_tail", 32'(level), 32'd1);
    step();
    out_ready = 1'b0;
    to_tick_end();
    to_tick_end();
    chk("mid_level3", 32'(level), 32'd3);
    chk("mid_drops_before", 32'(drop_count), 32'd2);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_data", out_data, 32'd0);
    chk("async_drops", 32'(drop_count), 32'd0);
    chk("async_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    audio0 = 8'd255; audio1 = 8'd255; audio2 = 8'd255; audio3 = 8'd255;
    reset = 1'b1;
    cyc = 0;
    repeat (3) step();
    chk("post_rst_valid_low", 32'(out_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", out_data, 32'h7F00_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
